// File: rtl/minority_detector.sv
// Registered 3-input minority/majority voter with ones count and an output-valid flag.
// All outputs come straight from flops, so they do not glitch when the inputs change.
module minority_detector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       f,
    output logic       maj,
    output logic [1:0] ones,
    output logic       f_valid
);

    logic       maj_d;
    logic       f_d;
    logic [1:0] ones_d;

    logic       f_q;
    logic       maj_q;
    logic [1:0] ones_q;
    logic       valid_q;

    always_comb begin
        maj_d  = (a & b) | (b & c) | (a & c);
        f_d    = ~maj_d;
        ones_d = {1'b0, a} + {1'b0, b} + {1'b0, c};
    end

    // f=0 together with maj=0 marks the outputs as invalid until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 1'b0;
            maj_q   <= 1'b0;
            ones_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            maj_q   <= maj_d;
            ones_q  <= ones_d;
            valid_q <= 1'b1;
        end
    end

    assign f       = f_q;
    assign maj     = maj_q;
    assign ones    = ones_q;
    assign f_valid = valid_q;

endmodule

// File: tb/tb_minority_detector.sv
// Scoreboard bench for minority_detector: the driver queues hand-computed results,
// and a monitor compares them against the registered outputs one cycle later.
module tb_minority_detector;

    typedef struct {
        logic       f;
        logic       maj;
        logic [1:0] ones;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       f;
    logic       maj;
    logic [1:0] ones;
    logic       f_valid;

    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb_q[$];

    // Hand-computed results for {a,b,c} = 0..7.
    logic       f_tab[8]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] ones_tab[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    minority_detector dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .f       (f),
        .maj     (maj),
        .ones    (ones),
        .f_valid (f_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one code on the falling edge and queues the result due after the next rising edge.
    task automatic apply(input logic [2:0] v);
        exp_t e;
        @(negedge clk);
        {a, b, c} = v;
        e.f    = f_tab[v];
        e.maj  = ~f_tab[v];
        e.ones = ones_tab[v];
        sb_q.push_back(e);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_f"},     {3'b0, f},       4'h0);
        chk({name, "_maj"},   {3'b0, maj},     4'h0);
        chk({name, "_ones"},  {2'b0, ones},    4'h0);
        chk({name, "_valid"}, {3'b0, f_valid}, 4'h0);
    endtask

    // Monitor: outputs are registered, so every rising edge out of reset presents one result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_f",     {3'b0, f},       {3'b0, e.f});
                chk("sb_maj",   {3'b0, maj},     {3'b0, e.maj});
                chk("sb_ones",  {2'b0, ones},    {2'b0, e.ones});
                chk("sb_valid", {3'b0, f_valid}, 4'h1);
                chk("sb_cons",  {3'b0, f},       {3'b0, (ones < 2'd2)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Reset with inputs high: outputs must clear without any clock edge.
        {a, b, c} = 3'b101;
        #1;
        rst_n = 1'b0;
        #1;
        chk_cleared("rst_async");
        @(posedge clk);
        #1;
        chk_cleared("rst_hold");

        // Release mid-cycle: nothing changes until the next rising edge.
        @(negedge clk);
        {a, b, c} = 3'b000;
        e.f = 1'b1; e.maj = 1'b0; e.ones = 2'd0;
        sb_q.push_back(e);
        #2;
        rst_n = 1'b1;
        #1;
        chk_cleared("rel_mid");

        for (int i = 1; i < 8; i++) apply(3'(i));

        // Latency: f stays 0 until the edge that samples 000.
        apply(3'b111);
        apply(3'b000);

        // Mid-run reset while f=1.
        apply(3'b001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("rst_mid");
        @(negedge clk);
        e.f = 1'b1; e.maj = 1'b0; e.ones = 2'd1;
        sb_q.push_back(e);
        #2;
        rst_n = 1'b1;
        #1;
        chk_cleared("rel_mid2");

        // Back-to-back toggling.
        for (int i = 0; i < 6; i++) apply((i % 2 == 0) ? 3'b000 : 3'b111);

        @(posedge clk);
        #3;
        chk("sb_drain", 4'(sb_q.size()), 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
